// File: rtl/hazard_ctrl.sv
// Hazard controller for the RV32I pipeline.
// It selects ALU operand forwarding sources and detects load-use stalls.
// It also holds a one-entry scoreboard for a fixed-latency MUL/DIV unit
// and a saturating counter of stall cycles.
module hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_FWD  = 3,
    parameter int unsigned LONG_LAT = 4,
    parameter int unsigned CNT_W    = 32,
    localparam int unsigned SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [REG_AW-1:0]         i_rs1_id,
    input  logic [REG_AW-1:0]         i_rs2_id,
    input  logic                      i_use_rs1_id,
    input  logic                      i_use_rs2_id,
    input  logic [REG_AW-1:0]         i_rd_id,
    input  logic                      i_long_id,
    input  logic [REG_AW-1:0]         i_rs1_ex,
    input  logic [REG_AW-1:0]         i_rs2_ex,
    input  logic [REG_AW-1:0]         i_rd_ex,
    input  logic                      i_regwen_ex,
    input  logic                      i_memread_ex,
    input  logic                      i_long_issue_ex,
    input  logic [NUM_FWD*REG_AW-1:0] i_rd_stg,
    input  logic [NUM_FWD-1:0]        i_regwen_stg,
    input  logic                      i_redirect,
    output logic [SEL_W-1:0]          o_fwd_sel_a,
    output logic [SEL_W-1:0]          o_fwd_sel_b,
    output logic                      o_stall_if,
    output logic                      o_stall_id,
    output logic                      o_flush_ex,
    output logic                      o_sb_busy,
    output logic                      o_sb_err,
    output logic [CNT_W-1:0]          o_stall_cnt
);

    logic              r_sb_busy;
    logic [REG_AW-1:0] r_sb_rd;
    logic [3:0]        r_sb_cnt;
    logic              r_sb_err;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [SEL_W-1:0]  w_sel_a;
    logic [SEL_W-1:0]  w_sel_b;
    logic              w_luh;
    logic              w_sbh;
    logic              w_stall;

    // Pick the youngest matching stage. The descending loop lets the lowest index win.
    // A source that waits on the outstanding long op reads the regfile,
    // because the ID stall covers that case.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
            if (i_regwen_stg[k] && i_rd_stg[k*REG_AW +: REG_AW] == i_rs1_ex && i_rs1_ex != '0)
                w_sel_a = SEL_W'(k + 1);
            if (i_regwen_stg[k] && i_rd_stg[k*REG_AW +: REG_AW] == i_rs2_ex && i_rs2_ex != '0)
                w_sel_b = SEL_W'(k + 1);
        end
        if (r_sb_busy && i_rs1_ex == r_sb_rd) w_sel_a = '0;
        if (r_sb_busy && i_rs2_ex == r_sb_rd) w_sel_b = '0;
        if (i_reset) begin
            w_sel_a = '0;
            w_sel_b = '0;
        end
    end

    // Detect load-use and scoreboard (RAW/WAW/structural) hazards; a redirect squashes the stall.
    always_comb begin
        w_luh = i_memread_ex && i_regwen_ex && (i_rd_ex != '0) &&
                ((i_use_rs1_id && i_rs1_id == i_rd_ex) ||
                 (i_use_rs2_id && i_rs2_id == i_rd_ex));
        w_sbh = r_sb_busy &&
                (((r_sb_rd != '0) &&
                  ((i_use_rs1_id && i_rs1_id == r_sb_rd) ||
                   (i_use_rs2_id && i_rs2_id == r_sb_rd) ||
                   (i_rd_id == r_sb_rd))) ||
                 i_long_id);
        w_stall = (w_luh || w_sbh) && !i_redirect && !i_reset;
    end

    // Scoreboard for the single long-latency unit; a second issue while busy is dropped and flagged.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sb_busy <= 1'b0;
            r_sb_rd   <= '0;
            r_sb_cnt  <= '0;
            r_sb_err  <= 1'b0;
        end else if (i_long_issue_ex && !r_sb_busy) begin
            r_sb_busy <= 1'b1;
            r_sb_rd   <= i_rd_ex;
            r_sb_cnt  <= 4'(LONG_LAT - 1);
        end else if (r_sb_busy) begin
            if (i_long_issue_ex) r_sb_err <= 1'b1;
            r_sb_cnt <= r_sb_cnt - 4'd1;
            if (r_sb_cnt == 4'd1) r_sb_busy <= 1'b0;
        end
    end

    // Count stalled cycles and stop at all-ones.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_fwd_sel_a = w_sel_a;
    assign o_fwd_sel_b = w_sel_b;
    assign o_stall_if  = w_stall;
    assign o_stall_id  = w_stall;
    assign o_flush_ex  = w_stall;
    assign o_sb_busy   = r_sb_busy;
    assign o_sb_err    = r_sb_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl.
// The stimulus side pushes a hand-computed expectation for each vector.
// A monitor pops it at the falling edge and compares it with the DUT outputs.
module tb_hazard_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned NUM_FWD = 3;
    localparam int unsigned CNT_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_id, rs2_id, rd_id, rs1_ex, rs2_ex, rd_ex;
    logic        use_rs1_id, use_rs2_id, long_id;
    logic        regwen_ex, memread_ex, long_issue_ex, redirect;
    logic [14:0] rd_stg;
    logic [2:0]  regwen_stg;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        stall_if, stall_id, flush_ex, sb_busy, sb_err;
    logic [31:0] stall_cnt;

    typedef struct {
        string       name;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic        busy;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_bad = 0;

    hazard_ctrl #(
        .REG_AW  (REG_AW),
        .NUM_FWD (NUM_FWD),
        .LONG_LAT(4),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_rs1_id       (rs1_id),
        .i_rs2_id       (rs2_id),
        .i_use_rs1_id   (use_rs1_id),
        .i_use_rs2_id   (use_rs2_id),
        .i_rd_id        (rd_id),
        .i_long_id      (long_id),
        .i_rs1_ex       (rs1_ex),
        .i_rs2_ex       (rs2_ex),
        .i_rd_ex        (rd_ex),
        .i_regwen_ex    (regwen_ex),
        .i_memread_ex   (memread_ex),
        .i_long_issue_ex(long_issue_ex),
        .i_rd_stg       (rd_stg),
        .i_regwen_stg   (regwen_stg),
        .i_redirect     (redirect),
        .o_fwd_sel_a    (fwd_sel_a),
        .o_fwd_sel_b    (fwd_sel_b),
        .o_stall_if     (stall_if),
        .o_stall_id     (stall_id),
        .o_flush_ex     (flush_ex),
        .o_sb_busy      (sb_busy),
        .o_sb_err       (sb_err),
        .o_stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare the oldest pending expectation away from the rising edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "fwd_sel_a", 32'(fwd_sel_a), 32'(e.fa));
            chk(e.name, "fwd_sel_b", 32'(fwd_sel_b), 32'(e.fb));
            chk(e.name, "stall_if", 32'(stall_if), 32'(e.st));
            chk(e.name, "stall_id", 32'(stall_id), 32'(e.st));
            chk(e.name, "flush_ex", 32'(flush_ex), 32'(e.st));
            chk(e.name, "sb_busy", 32'(sb_busy), 32'(e.busy));
            chk(e.name, "sb_err", 32'(sb_err), 32'(e.err));
            chk(e.name, "stall_cnt", stall_cnt, e.cnt);
        end
    end

    task automatic clear_in();
        rs1_id = 0; rs2_id = 0; rd_id = 0; use_rs1_id = 0; use_rs2_id = 0; long_id = 0;
        rs1_ex = 0; rs2_ex = 0; rd_ex = 0; regwen_ex = 0; memread_ex = 0;
        long_issue_ex = 0; rd_stg = '0; regwen_stg = '0; redirect = 0;
    endtask

    // Issue one vector: queue its expectation, let the monitor check it, move to next cycle
    task automatic step(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                        input logic st, input logic busy, input logic err,
                        input logic [31:0] cnt);
        exp_t e;
        e.name = nm; e.fa = fa; e.fb = fb; e.st = st; e.busy = busy; e.err = err; e.cnt = cnt;
        q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, got running expected finished");
        $fatal(1);
    end

    initial begin
        clear_in();
        reset = 1'b1;
        @(posedge clk); #1;
        step("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Forwarding priority
        regwen_stg = 3'b111; rd_stg = {5'd5, 5'd5, 5'd5}; rs1_ex = 5; rs2_ex = 7;
        step("fwd_youngest", 1, 0, 0, 0, 0, 0);
        regwen_stg = 3'b110;
        step("fwd_wb", 2, 0, 0, 0, 0, 0);
        regwen_stg = 3'b100; rs1_ex = 7; rs2_ex = 5;
        step("fwd_wb2_b", 0, 3, 0, 0, 0, 0);
        regwen_stg = 3'b111; rd_stg = '0; rs1_ex = 0; rs2_ex = 0;
        step("fwd_x0", 0, 0, 0, 0, 0, 0);
        clear_in();

        // Load-use: one bubble
        memread_ex = 1; regwen_ex = 1; rd_ex = 6; rs2_id = 6; use_rs2_id = 1;
        step("lu_stall", 0, 0, 1, 0, 0, 0);
        memread_ex = 0; regwen_ex = 0; rd_ex = 0;
        step("lu_after", 0, 0, 0, 0, 0, 1);
        memread_ex = 1; regwen_ex = 1; rd_ex = 6; use_rs2_id = 0;
        step("lu_nouse", 0, 0, 0, 0, 0, 1);
        clear_in();

        // Scoreboard RAW on x9
        long_issue_ex = 1; regwen_ex = 1; rd_ex = 9; rs1_id = 9; use_rs1_id = 1;
        step("sb_issue", 0, 0, 0, 0, 0, 1);
        long_issue_ex = 0; regwen_ex = 0; rd_ex = 0;
        step("sb_raw1", 0, 0, 1, 1, 0, 1);
        step("sb_raw2", 0, 0, 1, 1, 0, 2);
        regwen_stg = 3'b001; rd_stg = {5'd0, 5'd0, 5'd9}; rs1_ex = 9;
        step("sb_raw3_nofwd", 0, 0, 1, 1, 0, 3);
        step("sb_done_fwd", 1, 0, 0, 0, 0, 4);
        clear_in();

        // Unrelated, structural and WAW cases on x10
        long_issue_ex = 1; regwen_ex = 1; rd_ex = 10; rs1_id = 3; use_rs1_id = 1;
        step("sb_issue2", 0, 0, 0, 0, 0, 4);
        long_issue_ex = 0; regwen_ex = 0; rd_ex = 0;
        step("sb_unrelated", 0, 0, 0, 1, 0, 4);
        long_id = 1;
        step("sb_struct", 0, 0, 1, 1, 0, 4);
        long_id = 0; use_rs1_id = 0; rd_id = 10;
        step("sb_waw", 0, 0, 1, 1, 0, 5);
        step("sb_waw_done", 0, 0, 0, 0, 0, 6);
        clear_in();

        // Issue while busy: the error is sticky and the scoreboard keeps x11
        long_issue_ex = 1; regwen_ex = 1; rd_ex = 11;
        step("sb_issue3", 0, 0, 0, 0, 0, 6);
        rd_ex = 12;
        step("err_issue", 0, 0, 0, 1, 0, 6);
        long_issue_ex = 0; regwen_ex = 0; rd_ex = 0; rs1_id = 12; use_rs1_id = 1;
        step("err_sticky", 0, 0, 0, 1, 1, 6);

        // Redirect masks both load-use and scoreboard stalls
        memread_ex = 1; regwen_ex = 1; rd_ex = 6; rs2_id = 6; use_rs2_id = 1;
        rs1_id = 11; use_rs1_id = 1; redirect = 1;
        step("redirect", 0, 0, 0, 1, 1, 6);
        clear_in();
        step("redirect_after", 0, 0, 0, 0, 1, 6);

        // Async reset in the middle of a long op
        long_issue_ex = 1; regwen_ex = 1; rd_ex = 13;
        step("sb_issue4", 0, 0, 0, 0, 1, 6);
        long_issue_ex = 0; regwen_ex = 0; rd_ex = 0; rs1_id = 13; use_rs1_id = 1;
        step("pre_reset", 0, 0, 1, 1, 1, 6);
        reset = 1;
        regwen_stg = 3'b001; rd_stg = {5'd0, 5'd0, 5'd5}; rs1_ex = 5;
        memread_ex = 1; regwen_ex = 1; rd_ex = 13;
        step("async_reset", 0, 0, 0, 0, 0, 0);
        reset = 0;
        clear_in(); rs1_id = 13; use_rs1_id = 1;
        step("post_reset", 0, 0, 0, 0, 0, 0);

        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
